// File: rtl/npc_btb_pred.sv
// Fetch PC register with a direct-mapped BTB of 2-bit saturating counters.
// Predicts the next PC every cycle; accepts EX-stage updates and redirects.
module npc_btb_pred #(
  parameter int unsigned    AW       = 32,
  parameter int unsigned    DEPTH    = 16,
  parameter logic [AW-1:0]  RESET_PC = AW'(32'h0000_3000)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          stall,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  input  logic          upd_valid,
  input  logic [AW-1:0] upd_pc,
  input  logic          upd_taken,
  input  logic [AW-1:0] upd_target,
  output logic [AW-1:0] pc,
  output logic [AW-1:0] pc_plus4,
  output logic          pred_taken,
  output logic [AW-1:0] pred_target
);

  localparam int unsigned IDXW = $clog2(DEPTH);
  localparam int unsigned TAGW = AW - IDXW - 2;

  logic [AW-1:0]   r_pc;
  logic            r_valid  [DEPTH];
  logic [TAGW-1:0] r_tag    [DEPTH];
  logic [AW-1:0]   r_target [DEPTH];
  logic [1:0]      r_ctr    [DEPTH];

  logic [IDXW-1:0] w_idx;
  logic [TAGW-1:0] w_tag;
  logic            w_hit;
  logic            w_pred_taken;
  logic [AW-1:0]   w_pc_plus4;
  logic [AW-1:0]   w_pred_target;

  logic [IDXW-1:0] w_uidx;
  logic [TAGW-1:0] w_utag;
  logic            w_uhit;
  logic [1:0]      w_ctr_up;
  logic [1:0]      w_ctr_dn;

  // Fetch-side lookup, combinational on the current PC.
  always_comb begin
    w_idx         = r_pc[IDXW+1:2];
    w_tag         = r_pc[AW-1:IDXW+2];
    w_hit         = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    w_pred_taken  = w_hit && r_ctr[w_idx][1];
    w_pc_plus4    = r_pc + AW'(4);
    w_pred_target = w_pred_taken ? r_target[w_idx] : w_pc_plus4;
  end

  // Update-side lookup and saturating counter steps.
  always_comb begin
    w_uidx   = upd_pc[IDXW+1:2];
    w_utag   = upd_pc[AW-1:IDXW+2];
    w_uhit   = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);
    w_ctr_up = (r_ctr[w_uidx] == 2'b11) ? 2'b11 : r_ctr[w_uidx] + 2'b01;
    w_ctr_dn = (r_ctr[w_uidx] == 2'b00) ? 2'b00 : r_ctr[w_uidx] - 2'b01;
  end

  // Redirect beats stall; stall beats the prediction.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_pc <= {redirect_pc[AW-1:2], 2'b00};
    end else if (!stall) begin
      r_pc <= w_pred_target;
    end
  end

  // BTB write port; lookup above sees the pre-write contents this cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_valid[IDXW'(i)]  <= 1'b0;
        r_tag[IDXW'(i)]    <= '0;
        r_target[IDXW'(i)] <= '0;
        r_ctr[IDXW'(i)]    <= 2'b01;
      end
    end else if (upd_valid) begin
      if (w_uhit) begin
        if (upd_taken) begin
          r_ctr[w_uidx]    <= w_ctr_up;
          r_target[w_uidx] <= upd_target;
        end else begin
          r_ctr[w_uidx]    <= w_ctr_dn;
        end
      end else if (upd_taken) begin
        r_valid[w_uidx]  <= 1'b1;
        r_tag[w_uidx]    <= w_utag;
        r_target[w_uidx] <= upd_target;
        r_ctr[w_uidx]    <= 2'b10;
      end
    end
  end

  always_comb begin
    pc          = r_pc;
    pc_plus4    = w_pc_plus4;
    pred_taken  = w_pred_taken;
    pred_target = w_pred_target;
  end

endmodule

// File: tb/tb_npc_btb_pred.sv
// Directed bench for npc_btb_pred: stimulus pushes expected per-cycle outputs,
// a negedge monitor pops and compares them.
module tb_npc_btb_pred;

  logic        clk;
  logic        rstn;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        pred_taken;
  logic [31:0] pred_target;

  typedef struct {
    logic [31:0] pc;
    logic        pt;
    logic [31:0] tgt;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  npc_btb_pred dut (
    .clk            (clk),
    .rstn           (rstn),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_taken      (upd_taken),
    .upd_target     (upd_target),
    .pc             (pc),
    .pc_plus4       (pc_plus4),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, req);
    end
  endtask

  // Monitor: outputs are valid every cycle; compare mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("pc",          pc,                 e.pc);
      chk("pc_plus4",    pc_plus4,           e.pc + 32'd4);
      chk("pred_taken",  {31'd0, pred_taken}, {31'd0, e.pt});
      chk("pred_target", pred_target,        e.tgt);
    end
  end

  // One cycle: drive inputs just after the edge, queue this cycle's expected outputs.
  task automatic cyc(input logic rst_v, input logic st, input logic rv, input logic [31:0] rpc,
                     input logic uv, input logic [31:0] upc, input logic ut, input logic [31:0] utgt,
                     input logic [31:0] epc, input logic ept, input logic [31:0] etgt);
    exp_t e;
    @(posedge clk);
    #1;
    rstn           = rst_v;
    stall          = st;
    redirect_valid = rv;
    redirect_pc    = rpc;
    upd_valid      = uv;
    upd_pc         = upd_pc_or(uv, upc);
    upd_taken      = ut;
    upd_target     = utgt;
    e.pc  = epc;
    e.pt  = ept;
    e.tgt = etgt;
    q.push_back(e);
  endtask

  function automatic logic [31:0] upd_pc_or(input logic uv, input logic [31:0] upc);
    return uv ? upc : 32'h0;
  endfunction

  localparam logic [31:0] Z = 32'h0;

  initial begin
    rstn = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;

    // rst st rv rpc  uv upc ut utgt  exp_pc pt exp_tgt
    cyc(0,0,0,Z, 0,Z,0,Z, 32'h3000,0,32'h3004);                         // in reset
    cyc(1,0,0,Z, 0,Z,0,Z, 32'h3000,0,32'h3004);                         // release
    cyc(1,0,0,Z, 0,Z,0,Z, 32'h3004,0,32'h3008);
    cyc(1,0,0,Z, 0,Z,0,Z, 32'h3008,0,32'h300C);
    cyc(0,0,0,Z, 0,Z,0,Z, 32'h3000,0,32'h3004);                         // async reset mid-cycle
    cyc(1,0,0,Z, 0,Z,0,Z, 32'h3000,0,32'h3004);
    cyc(1,0,0,Z, 1,32'h3010,1,32'h3100, 32'h3004,0,32'h3008);           // alloc 3010->3100
    cyc(1,0,0,Z, 0,Z,0,Z, 32'h3008,0,32'h300C);
    cyc(1,0,0,Z, 0,Z,0,Z, 32'h300C,0,32'h3010);
    cyc(1,0,0,Z, 0,Z,0,Z, 32'h3010,1,32'h3100);                         // hit, ctr=10
    cyc(1,0,1,32'h3010, 1,32'h3010,0,Z, 32'h3100,0,32'h3104);           // nt: 10->01
    cyc(1,0,1,32'h3010, 1,32'h3010,0,Z, 32'h3010,0,32'h3014);           // ctr=01; nt ->00
    cyc(1,0,1,32'h3010, 1,32'h3010,0,Z, 32'h3010,0,32'h3014);           // ctr=00; nt stays 00
    cyc(1,0,1,32'h3010, 1,32'h3010,1,32'h3100, 32'h3010,0,32'h3014);    // ctr=00; t ->01
    cyc(1,0,1,32'h3010, 1,32'h3010,1,32'h3100, 32'h3010,0,32'h3014);    // ctr=01; t ->10
    cyc(1,0,1,32'h3010, 1,32'h3010,1,32'h3100, 32'h3010,1,32'h3100);    // ctr=10; t ->11
    cyc(1,0,1,32'h3010, 1,32'h3010,1,32'h3100, 32'h3010,1,32'h3100);    // ctr=11; t stays 11
    cyc(1,0,1,32'h3010, 1,32'h3010,0,Z, 32'h3010,1,32'h3100);           // ctr=11; nt ->10
    cyc(1,0,1,32'h3010, 1,32'h3050,1,32'h3200, 32'h3010,1,32'h3100);    // ctr=10; alias overwrite
    cyc(1,0,1,32'h3050, 0,Z,0,Z, 32'h3010,0,32'h3014);                  // tag mismatch now
    cyc(1,0,0,Z, 0,Z,0,Z, 32'h3050,1,32'h3200);                         // alias hit
    cyc(1,1,1,32'h3403, 0,Z,0,Z, 32'h3200,0,32'h3204);                  // redirect beats stall
    cyc(1,1,0,Z, 0,Z,0,Z, 32'h3400,0,32'h3404);
    cyc(1,1,0,Z, 0,Z,0,Z, 32'h3400,0,32'h3404);
    cyc(1,0,0,Z, 0,Z,0,Z, 32'h3400,0,32'h3404);
    cyc(1,0,1,32'h3010, 0,Z,0,Z, 32'h3404,0,32'h3408);
    cyc(1,0,1,32'h3010, 1,32'h3010,1,32'h3100, 32'h3010,0,32'h3014);    // same-cycle: old contents
    cyc(1,0,0,Z, 0,Z,0,Z, 32'h3010,1,32'h3100);                         // new contents visible
    cyc(1,0,1,32'hFFFF_FFFE, 0,Z,0,Z, 32'h3100,0,32'h3104);
    cyc(1,0,0,Z, 0,Z,0,Z, 32'hFFFF_FFFC,0,32'h0000_0000);               // pc+4 wraps
    cyc(0,1,0,Z, 1,32'h3010,1,32'h3100, 32'h3000,0,32'h3004);           // reset mid-stall/update
    cyc(1,0,1,32'h3010, 0,Z,0,Z, 32'h3000,0,32'h3004);
    cyc(1,0,0,Z, 0,Z,0,Z, 32'h3010,0,32'h3014);                         // BTB cleared by reset
    cyc(1,0,0,Z, 0,Z,0,Z, 32'h3014,0,32'h3018);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      n_errors++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
